// File: rtl/reg_file_rename.sv
// Architectural register file x0..x31 with per-register rename (busy/tag) state.
// Issue allocates a ROB tag to a destination; commit writes the value and releases the owning tag.
module reg_file_rename #(
    parameter int unsigned ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy_i,
    input  logic               flush_i,
    input  logic               commit_enable_i,
    input  logic [4:0]         commit_index_i,
    input  logic [ROB_LOG-1:0] commit_rob_id_i,
    input  logic [31:0]        commit_value_i,
    input  logic               issue_valid_i,
    input  logic [4:0]         issue_dest_i,
    input  logic [ROB_LOG-1:0] issue_rob_id_i,
    input  logic [4:0]         rs1_index_i,
    input  logic [4:0]         rs2_index_i,
    output logic               rs1_busy_o,
    output logic [ROB_LOG-1:0] rs1_tag_o,
    output logic [31:0]        rs1_value_o,
    output logic               rs2_busy_o,
    output logic [ROB_LOG-1:0] rs2_tag_o,
    output logic [31:0]        rs2_value_o
);

    logic [31:0]        value_q [32];
    logic [31:0]        value_d [32];
    logic [ROB_LOG-1:0] tag_q   [32];
    logic [ROB_LOG-1:0] tag_d   [32];
    logic [31:0]        busy_q;
    logic [31:0]        busy_d;

    logic commit_act;
    logic issue_act;

    assign commit_act = rdy_i && commit_enable_i && (commit_index_i != 5'd0);
    assign issue_act  = rdy_i && !flush_i && issue_valid_i && (issue_dest_i != 5'd0);

    // Later assignments take priority: flush over commit release, issue over commit release.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (commit_act) begin
            value_d[commit_index_i] = commit_value_i;
            if (busy_q[commit_index_i] && (tag_q[commit_index_i] == commit_rob_id_i)) begin
                busy_d[commit_index_i] = 1'b0;
            end
        end
        if (rdy_i && flush_i) begin
            busy_d = '0;
        end
        if (issue_act) begin
            busy_d[issue_dest_i] = 1'b1;
            tag_d[issue_dest_i]  = issue_rob_id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    logic [4:0]         q_idx   [2];
    logic               q_busy  [2];
    logic [ROB_LOG-1:0] q_tag   [2];
    logic [31:0]        q_value [2];

    assign q_idx[0] = rs1_index_i;
    assign q_idx[1] = rs2_index_i;

    // A same-cycle commit to the queried register is forwarded to the issue stage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            q_busy[p]  = busy_q[q_idx[p]];
            q_tag[p]   = tag_q[q_idx[p]];
            q_value[p] = value_q[q_idx[p]];
            if (commit_act && (commit_index_i == q_idx[p])) begin
                q_busy[p]  = busy_q[q_idx[p]] && (tag_q[q_idx[p]] != commit_rob_id_i);
                q_value[p] = commit_value_i;
            end
            if (q_idx[p] == 5'd0) begin
                q_busy[p]  = 1'b0;
                q_tag[p]   = '0;
                q_value[p] = '0;
            end
        end
    end

    assign rs1_busy_o  = q_busy[0];
    assign rs1_tag_o   = q_tag[0];
    assign rs1_value_o = q_value[0];
    assign rs2_busy_o  = q_busy[1];
    assign rs2_tag_o   = q_tag[1];
    assign rs2_value_o = q_value[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed, table-driven bench for reg_file_rename: each row is one cycle of inputs plus the
// query outputs expected in that same cycle, before the clock edge.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, ce, iv;
    logic [4:0]  ci, id, r1, r2;
    logic [3:0]  crid, irid;
    logic [31:0] cv;
    logic        b1, b2;
    logic [3:0]  t1, t2;
    logic [31:0] v1, v2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_rename #(.ROB_LOG(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy_i           (rdy),
        .flush_i         (flush),
        .commit_enable_i (ce),
        .commit_index_i  (ci),
        .commit_rob_id_i (crid),
        .commit_value_i  (cv),
        .issue_valid_i   (iv),
        .issue_dest_i    (id),
        .issue_rob_id_i  (irid),
        .rs1_index_i     (r1),
        .rs2_index_i     (r2),
        .rs1_busy_o      (b1),
        .rs1_tag_o       (t1),
        .rs1_value_o     (v1),
        .rs2_busy_o      (b2),
        .rs2_tag_o       (t2),
        .rs2_value_o     (v2)
    );

    typedef struct {
        logic        rst, rdy, flush, ce;
        logic [4:0]  ci;
        logic [3:0]  crid;
        logic [31:0] cv;
        logic        iv;
        logic [4:0]  id;
        logic [3:0]  irid;
        logic [4:0]  r1, r2;
        logic        eb1;
        logic [3:0]  et1;
        logic [31:0] ev1;
        logic        eb2;
        logic [3:0]  et2;
        logic [31:0] ev2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rst_v, int rdy_v, int fl, int ce_v, int ci_v, int crid_v,
                                logic [31:0] cv_v, int iv_v, int id_v, int irid_v, int r1_v,
                                int r2_v, int eb1, int et1, logic [31:0] ev1, int eb2, int et2,
                                logic [31:0] ev2);
        vec_t r;
        r.rst = 1'(rst_v);  r.rdy = 1'(rdy_v);  r.flush = 1'(fl);  r.ce = 1'(ce_v);
        r.ci = 5'(ci_v);    r.crid = 4'(crid_v); r.cv = cv_v;
        r.iv = 1'(iv_v);    r.id = 5'(id_v);    r.irid = 4'(irid_v);
        r.r1 = 5'(r1_v);    r.r2 = 5'(r2_v);
        r.eb1 = 1'(eb1);    r.et1 = 4'(et1);    r.ev1 = ev1;
        r.eb2 = 1'(eb2);    r.et2 = 4'(et2);    r.ev2 = ev2;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0; ce = 1'b0; ci = '0; crid = '0; cv = '0;
        iv = 1'b0; id = '0; irid = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1; r1 = '0; r2 = '0;
        repeat (2) @(posedge clk);

        //         rst rdy fl ce ci crid cv        iv id irid r1 r2  b1 t1 v1      b2 t2 v2
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  5, 31, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1,  0, 0, 32'hDEAD, 0, 0, 0,  0,  0, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 0, 3,  0,  0, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 3, 7,  0,  3, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  3,  3, 1, 7, 32'h0,  1, 7, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1,  3, 7, 32'h1234, 0, 0, 0,  3,  5, 0, 7, 32'h1234, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  3,  0, 0, 7, 32'h1234, 0, 0, 32'h0));
        // stale commit: x4 re-tagged 2 -> 9
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 4, 2,  4,  0, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 4, 9,  4,  0, 1, 2, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1,  4, 2, 32'hAA,   0, 0, 0,  4,  4, 1, 9, 32'hAA, 1, 9, 32'hAA));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  4,  0, 1, 9, 32'hAA, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1,  4, 9, 32'hBB,   0, 0, 0,  4,  0, 0, 9, 32'hBB, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  4,  0, 0, 9, 32'hBB, 0, 0, 32'h0));
        // same-cycle issue and commit on x6: issue wins
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 6, 1,  6,  0, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1,  6, 1, 32'h77,   1, 6, 5,  6,  0, 0, 1, 32'h77, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  6,  0, 1, 5, 32'h77, 0, 0, 32'h0));
        // flush with commit and issue in the same cycle
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 1, 3,  1,  2, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 2, 4,  1,  2, 1, 3, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1,  1, 3, 32'h40,   1, 8, 6,  1,  2, 0, 3, 32'h40, 1, 4, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  1,  2, 0, 3, 32'h40, 0, 4, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  8,  6, 0, 0, 32'h0,  0, 5, 32'h77));
        // stall: rdy=0 freezes state and disables bypass
        vecs.push_back(mk(0, 1, 0, 1, 11, 0, 32'h11,   0, 0, 0, 11,  0, 0, 0, 32'h11, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 11, 0, 32'h55,   1, 10, 1, 11, 10, 0, 0, 32'h11, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    1, 12, 13, 10, 11, 0, 0, 32'h0, 0, 0, 32'h11));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 32'h0,    0, 0, 0, 12,  0, 1, 13, 32'h0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0, 12,  0, 1, 13, 32'h0, 0, 0, 32'h0));
        // mid-stream reset beats commit and issue
        vecs.push_back(mk(1, 1, 0, 1, 12, 13, 32'h99,  1, 7, 2, 12,  0, 0, 13, 32'h99, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0, 12, 11, 0, 0, 32'h0,  0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0, 32'h0,    0, 0, 0,  7,  4, 0, 0, 32'h0,  0, 0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;  rdy = vecs[i].rdy;  flush = vecs[i].flush;
            ce = vecs[i].ce;    ci = vecs[i].ci;    crid = vecs[i].crid;  cv = vecs[i].cv;
            iv = vecs[i].iv;    id = vecs[i].id;    irid = vecs[i].irid;
            r1 = vecs[i].r1;    r2 = vecs[i].r2;
            #1;
            check($sformatf("row%0d rs1_busy", i), 32'(b1), 32'(vecs[i].eb1));
            check($sformatf("row%0d rs1_tag", i), 32'(t1), 32'(vecs[i].et1));
            check($sformatf("row%0d rs1_value", i), v1, vecs[i].ev1);
            check($sformatf("row%0d rs2_busy", i), 32'(b2), 32'(vecs[i].eb2));
            check($sformatf("row%0d rs2_tag", i), 32'(t2), 32'(vecs[i].et2));
            check($sformatf("row%0d rs2_value", i), v2, vecs[i].ev2);
        end

        // Reset wins even while stalled and flushing.
        @(negedge clk);
        idle();
        iv = 1'b1; id = 5'd20; irid = 4'd15;
        ce = 1'b1; ci = 5'd21; cv = 32'hCAFE;
        r1 = 5'd20; r2 = 5'd21;
        #1;
        check("seq bypass x21 value", v2, 32'hCAFE);
        @(negedge clk);
        idle();
        #1;
        check("seq x20 busy", 32'(b1), 32'd1);
        check("seq x20 tag", 32'(t1), 32'd15);
        check("seq x21 value", v2, 32'hCAFE);
        @(negedge clk);
        rst = 1'b1; rdy = 1'b0; flush = 1'b1;
        #1;
        check("seq pre-reset x20 busy", 32'(b1), 32'd1);
        @(negedge clk);
        idle();
        #1;
        check("seq post-reset x20 busy", 32'(b1), 32'd0);
        check("seq post-reset x20 tag", 32'(t1), 32'd0);
        check("seq post-reset x21 value", v2, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
